// File: rtl/orb_pkg.sv
// orb_pkg -- shared constants and types for the ORB frame scheduler.
//
// Holds the frame marker words, the default idle filler word, the frame
// dimensions (words per phrase, phrases per group, groups per cycle) and
// the scheduler state encoding. Imported by orb_rr_arb and orb_frame_sched.
package orb_pkg;

    // Marker words placed in slot 0 of every phrase
    localparam logic [11:0] ORB_MARK_CYCLE  = 12'hFFF;
    localparam logic [11:0] ORB_MARK_GROUP  = 12'hF0F;
    localparam logic [11:0] ORB_MARK_PHRASE = 12'h0F0;

    // Filler sent in a data slot when nobody is requesting
    localparam logic [11:0] ORB_IDLE_WORD   = 12'h666;

    // Frame dimensions
    localparam int ORB_WORDS_PER_PHRASE  = 16;
    localparam int ORB_PHRASES_PER_GROUP = 128;
    localparam int ORB_GROUPS_PER_CYCLE  = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ISSUE = 2'd2
    } orb_state_t;

endpackage

// File: rtl/orb_rr_arb.sv
// orb_rr_arb -- combinational round-robin arbiter.
//
// Searches req starting at index ptr and wrapping around; the first asserted
// bit wins.
// Ports:
//   req  [NREQ-1:0]  request flags
//   ptr  [PW-1:0]    highest-priority index for this decision
//   gnt  [NREQ-1:0]  one-hot grant (all zero when req is zero)
//   idx  [PW-1:0]    index of the granted requester
//   any              at least one request was granted
module orb_rr_arb
    import orb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   idx,
    output logic            any
);

    logic [PW-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int off = 0; off < NREQ; off++) begin
            cand = PW'((int'(ptr) + off) % NREQ);
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/orb_frame_sched.sv
// orb_frame_sched -- frame scheduler feeding 12-bit words to a serializer.
//
// Each word_rdy pulse (accepted only in WAIT) yields one registered word one
// clock later. Slot 0 of every 16-word phrase carries a marker (cycle, group
// or phrase); slots 1..15 carry round-robin data from the requesters or the
// idle filler word. Frame: 16 words/phrase, 128 phrases/group, 32 groups/cycle.
//
// Ports:
//   clk          system clock
//   clr          asynchronous active-low reset
//   en           stream enable; low forces IDLE and clears the frame position
//   word_rdy     serializer request for the next word (single-cycle pulse)
//   req          per-requester data-pending flags
//   req_data     packed data words, requester i at [12i+11:12i]
//   word_o       word to the serializer
//   word_vld     single-cycle qualifier for word_o
//   gnt          one-hot grant, coincident with word_vld
//   phrase_cnt   phrase index of the word on word_o
//   group_cnt    group index of the word on word_o
//   cycle_start  pulses with the cycle marker word
//   err          sticky: word_rdy seen outside WAIT while enabled
//
// Configuration macro: ORB_SCHED_PARITY_EN -- when defined, bit 11 of every
// data/idle word is replaced by odd parity over bits 10:0. Markers untouched.
//
// CYCLE_GROUPS defaults to the package frame size; it only exists so a
// shortened cycle can be instantiated.
module orb_frame_sched
    import orb_pkg::*;
#(
    parameter int          NREQ         = 4,
    parameter logic [11:0] IDLE_WORD    = ORB_IDLE_WORD,
    parameter int          CYCLE_GROUPS = ORB_GROUPS_PER_CYCLE
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 word_rdy,
    input  logic [NREQ-1:0]      req,
    input  logic [12*NREQ-1:0]   req_data,
    output logic [11:0]          word_o,
    output logic                 word_vld,
    output logic [NREQ-1:0]      gnt,
    output logic [6:0]           phrase_cnt,
    output logic [4:0]           group_cnt,
    output logic                 cycle_start,
    output logic                 err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    orb_state_t      state, next_state;
    logic            issue, bad_rdy;

    logic [3:0]      word_cnt;
    logic [6:0]      phr_pos;
    logic [4:0]      grp_pos;
    logic [PW-1:0]   ptr;

    logic [NREQ-1:0] arb_gnt;
    logic [PW-1:0]   arb_idx;
    logic            arb_any;

    logic [11:0]     data_sel, fill_word, slot_word;
    logic            slot0;

    orb_rr_arb #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req (req),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= ST_IDLE;
        else      state <= next_state;
    end

    // word_rdy is only honoured in WAIT; elsewhere (while enabled) it flags err
    always_comb begin
        next_state = state;
        issue      = 1'b0;
        bad_rdy    = 1'b0;
        if (!en) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    next_state = ST_WAIT;
                    bad_rdy    = word_rdy;
                end
                ST_WAIT: begin
                    if (word_rdy) begin
                        next_state = ST_ISSUE;
                        issue      = 1'b1;
                    end
                end
                ST_ISSUE: begin
                    next_state = ST_WAIT;
                    bad_rdy    = word_rdy;
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        data_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_idx == PW'(i)) data_sel = req_data[12*i +: 12];
        end
        fill_word = arb_any ? data_sel : IDLE_WORD;
`ifdef ORB_SCHED_PARITY_EN
        fill_word[11] = ~^fill_word[10:0];
`else
`endif
        slot0 = (word_cnt == 4'd0);
        if (slot0) begin
            if (phr_pos == 7'd0 && grp_pos == 5'd0) slot_word = ORB_MARK_CYCLE;
            else if (phr_pos == 7'd0)               slot_word = ORB_MARK_GROUP;
            else                                    slot_word = ORB_MARK_PHRASE;
        end else begin
            slot_word = fill_word;
        end
    end

    // Output register and frame position. phrase_cnt/group_cnt are captured
    // with the word so they describe the slot being delivered, not the next.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            word_o      <= '0;
            word_vld    <= 1'b0;
            gnt         <= '0;
            cycle_start <= 1'b0;
            err         <= 1'b0;
            phrase_cnt  <= '0;
            group_cnt   <= '0;
            word_cnt    <= '0;
            phr_pos     <= '0;
            grp_pos     <= '0;
            ptr         <= '0;
        end else begin
            word_vld    <= 1'b0;
            gnt         <= '0;
            cycle_start <= 1'b0;
            if (bad_rdy) err <= 1'b1;
            if (state == ST_IDLE) begin
                word_cnt   <= '0;
                phr_pos    <= '0;
                grp_pos    <= '0;
                ptr        <= '0;
                phrase_cnt <= '0;
                group_cnt  <= '0;
            end else if (issue) begin
                word_o      <= slot_word;
                word_vld    <= 1'b1;
                phrase_cnt  <= phr_pos;
                group_cnt   <= grp_pos;
                cycle_start <= slot0 && (phr_pos == 7'd0) && (grp_pos == 5'd0);
                if (!slot0 && arb_any) begin
                    gnt <= arb_gnt;
                    ptr <= (arb_idx == PW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
                end
                if (word_cnt == 4'(ORB_WORDS_PER_PHRASE - 1)) begin
                    word_cnt <= '0;
                    if (phr_pos == 7'(ORB_PHRASES_PER_GROUP - 1)) begin
                        phr_pos <= '0;
                        grp_pos <= (grp_pos == 5'(CYCLE_GROUPS - 1)) ? 5'd0 : grp_pos + 5'd1;
                    end else begin
                        phr_pos <= phr_pos + 7'd1;
                    end
                end else begin
                    word_cnt <= word_cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_orb_frame_sched.sv
// tb_orb_frame_sched -- directed self-checking bench for orb_frame_sched.
// A second instance with a 2-group cycle exercises the cycle wrap quickly.
// Honours ORB_SCHED_PARITY_EN for the expected data/idle words.
module tb_orb_frame_sched;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        en = 1'b0;
    logic        word_rdy = 1'b0;
    logic [3:0]  req = '0;
    logic [47:0] req_data = {12'h004, 12'h003, 12'h002, 12'h001};

    logic [11:0] word_o;
    logic        word_vld;
    logic [3:0]  gnt;
    logic [6:0]  phrase_cnt;
    logic [4:0]  group_cnt;
    logic        cycle_start;
    logic        err;

    logic [11:0] s_word_o;
    logic        s_word_vld;
    logic [3:0]  s_gnt;
    logic [6:0]  s_phrase_cnt;
    logic [4:0]  s_group_cnt;
    logic        s_cycle_start;
    logic        s_err;

    int checks = 0;
    int failures = 0;

`ifdef ORB_SCHED_PARITY_EN
    localparam logic [11:0] EXP_IDLE = 12'hE66;
    logic [11:0] exp_data [4] = '{12'h001, 12'h002, 12'h803, 12'h004};
`else
    localparam logic [11:0] EXP_IDLE = 12'h666;
    logic [11:0] exp_data [4] = '{12'h001, 12'h002, 12'h003, 12'h004};
`endif

    orb_frame_sched dut (
        .clk(clk), .clr(clr), .en(en), .word_rdy(word_rdy),
        .req(req), .req_data(req_data),
        .word_o(word_o), .word_vld(word_vld), .gnt(gnt),
        .phrase_cnt(phrase_cnt), .group_cnt(group_cnt),
        .cycle_start(cycle_start), .err(err)
    );

    orb_frame_sched #(.CYCLE_GROUPS(2)) dut_short (
        .clk(clk), .clr(clr), .en(en), .word_rdy(word_rdy),
        .req(req), .req_data(req_data),
        .word_o(s_word_o), .word_vld(s_word_vld), .gnt(s_gnt),
        .phrase_cnt(s_phrase_cnt), .group_cnt(s_group_cnt),
        .cycle_start(s_cycle_start), .err(s_err)
    );

    always #5 clk = ~clk;

    // One word request: entered and left on a falling edge, outputs of the
    // issued word are stable on return.
    task automatic pulse_word();
        @(negedge clk);
        word_rdy = 1'b1;
        @(negedge clk);
        word_rdy = 1'b0;
    endtask

    task automatic restart();
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
    endtask

    task automatic test_reset();
        clr = 1'b0; en = 1'b0; word_rdy = 1'b0; req = '0;
        #1;
        checks++; if (word_o !== 12'h000) begin failures++; $display("[TB] FAIL reset_word: got %h want 000", word_o); end
        checks++; if ({word_vld, gnt, cycle_start, err} !== 7'b0) begin failures++; $display("[TB] FAIL reset_flags: got %b want 0000000", {word_vld, gnt, cycle_start, err}); end
        checks++; if ({phrase_cnt, group_cnt} !== 12'h000) begin failures++; $display("[TB] FAIL reset_pos: got %h want 000", {phrase_cnt, group_cnt}); end
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        en  = 1'b1;
    endtask

    task automatic test_first_marker();
        pulse_word();
        checks++; if (word_o !== 12'hFFF) begin failures++; $display("[TB] FAIL first_word: got %h want fff", word_o); end
        checks++; if (word_vld !== 1'b1) begin failures++; $display("[TB] FAIL first_vld: got %b want 1", word_vld); end
        checks++; if (cycle_start !== 1'b1) begin failures++; $display("[TB] FAIL first_cycle_start: got %b want 1", cycle_start); end
        checks++; if (gnt !== 4'b0000) begin failures++; $display("[TB] FAIL first_gnt: got %b want 0000", gnt); end
        @(negedge clk);
        checks++; if (word_vld !== 1'b0) begin failures++; $display("[TB] FAIL vld_single_cycle: got %b want 0", word_vld); end
    endtask

    task automatic test_round_robin();
        req = 4'b1111;
        for (int s = 1; s <= 8; s++) begin
            pulse_word();
            checks++; if (gnt !== 4'(1 << ((s - 1) % 4))) begin failures++; $display("[TB] FAIL rr_gnt slot %0d: got %b want %b", s, gnt, 4'(1 << ((s - 1) % 4))); end
            checks++; if (word_o !== exp_data[(s - 1) % 4] || word_vld !== 1'b1) begin failures++; $display("[TB] FAIL rr_word slot %0d: got %h/%b want %h/1", s, word_o, word_vld, exp_data[(s - 1) % 4]); end
        end
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL rr_err: got %b want 0", err); end
    endtask

    task automatic test_idle_fill();
        restart();
        req = 4'b1111;
        pulse_word();
        checks++; if (word_o !== 12'hFFF || cycle_start !== 1'b1) begin failures++; $display("[TB] FAIL restart_marker: got %h/%b want fff/1", word_o, cycle_start); end
        for (int s = 1; s <= 4; s++) pulse_word();
        req = 4'b0000;
        pulse_word();
        checks++; if (word_o !== EXP_IDLE || word_vld !== 1'b1) begin failures++; $display("[TB] FAIL idle_word: got %h/%b want %h/1", word_o, word_vld, EXP_IDLE); end
        checks++; if (gnt !== 4'b0000) begin failures++; $display("[TB] FAIL idle_gnt: got %b want 0000", gnt); end
        req = 4'b1111;
        pulse_word();
        checks++; if (gnt !== 4'b0001 || word_o !== exp_data[0]) begin failures++; $display("[TB] FAIL ptr_hold: got %b/%h want 0001/%h", gnt, word_o, exp_data[0]); end
        req = 4'b1001;
        pulse_word();
        checks++; if (gnt !== 4'b1000 || word_o !== exp_data[3]) begin failures++; $display("[TB] FAIL rr_skip: got %b/%h want 1000/%h", gnt, word_o, exp_data[3]); end
        pulse_word();
        checks++; if (gnt !== 4'b0001 || word_o !== exp_data[0]) begin failures++; $display("[TB] FAIL rr_wrap: got %b/%h want 0001/%h", gnt, word_o, exp_data[0]); end
    endtask

    task automatic test_back_to_back();
        restart();
        req = 4'b0000;
        for (int s = 0; s < 15; s++) pulse_word();
        @(negedge clk);
        word_rdy = 1'b1;
        @(negedge clk);
        checks++; if (word_o !== EXP_IDLE || word_vld !== 1'b1) begin failures++; $display("[TB] FAIL b2b_first: got %h/%b want %h/1", word_o, word_vld, EXP_IDLE); end
        @(negedge clk);
        word_rdy = 1'b0;
        checks++; if (word_vld !== 1'b0) begin failures++; $display("[TB] FAIL b2b_ignored: got %b want 0", word_vld); end
        checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL b2b_err: got %b want 1", err); end
        req = 4'b1111;
        pulse_word();
        checks++; if (word_o !== 12'h0F0 || phrase_cnt !== 7'd1 || gnt !== 4'b0000) begin failures++; $display("[TB] FAIL b2b_next_marker: got %h/%0d/%b want 0f0/1/0000", word_o, phrase_cnt, gnt); end
        pulse_word();
        checks++; if (gnt !== 4'b0001 || word_o !== exp_data[0]) begin failures++; $display("[TB] FAIL b2b_next_data: got %b/%h want 0001/%h", gnt, word_o, exp_data[0]); end
        checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL err_sticky: got %b want 1", err); end
    endtask

    task automatic test_frame_wrap();
        @(negedge clk);
        clr = 1'b0; en = 1'b0; req = '0;
        @(negedge clk);
        clr = 1'b1; en = 1'b1;
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL err_reset: got %b want 0", err); end
        for (int n = 0; n < 2047; n++) pulse_word();
        pulse_word();
        checks++; if (word_o !== EXP_IDLE || phrase_cnt !== 7'd127 || group_cnt !== 5'd0) begin failures++; $display("[TB] FAIL word2047: got %h/%0d/%0d want %h/127/0", word_o, phrase_cnt, group_cnt, EXP_IDLE); end
        pulse_word();
        checks++; if (word_o !== 12'hF0F || group_cnt !== 5'd1 || phrase_cnt !== 7'd0 || cycle_start !== 1'b0) begin failures++; $display("[TB] FAIL word2048: got %h/%0d/%0d/%b want f0f/1/0/0", word_o, group_cnt, phrase_cnt, cycle_start); end
        checks++; if (s_word_o !== 12'hF0F || s_group_cnt !== 5'd1) begin failures++; $display("[TB] FAIL short_word2048: got %h/%0d want f0f/1", s_word_o, s_group_cnt); end
        for (int n = 2049; n < 4096; n++) pulse_word();
        pulse_word();
        checks++; if (word_o !== 12'hF0F || group_cnt !== 5'd2) begin failures++; $display("[TB] FAIL word4096: got %h/%0d want f0f/2", word_o, group_cnt); end
        checks++; if (s_word_o !== 12'hFFF || s_group_cnt !== 5'd0 || s_cycle_start !== 1'b1 || s_word_vld !== 1'b1) begin failures++; $display("[TB] FAIL short_cycle_wrap: got %h/%0d/%b/%b want fff/0/1/1", s_word_o, s_group_cnt, s_cycle_start, s_word_vld); end
    endtask

    task automatic test_reset_in_issue();
        req = 4'b1111;
        @(negedge clk);
        word_rdy = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (word_vld !== 1'b1 || gnt !== 4'b0001) begin failures++; $display("[TB] FAIL pre_reset_issue: got %b/%b want 1/0001", word_vld, gnt); end
        clr = 1'b0;
        #1;
        word_rdy = 1'b0;
        checks++; if (word_vld !== 1'b0 || gnt !== 4'b0000 || word_o !== 12'h000) begin failures++; $display("[TB] FAIL async_drop: got %b/%b/%h want 0/0000/000", word_vld, gnt, word_o); end
        @(negedge clk);
        clr = 1'b1;
        pulse_word();
        checks++; if (word_o !== 12'hFFF || word_vld !== 1'b1 || cycle_start !== 1'b1 || gnt !== 4'b0000) begin failures++; $display("[TB] FAIL restart_word: got %h/%b/%b/%b want fff/1/1/0000", word_o, word_vld, cycle_start, gnt); end
        checks++; if (s_err !== 1'b0) begin failures++; $display("[TB] FAIL short_err: got %b want 0", s_err); end
    endtask

    initial begin
        test_reset();
        test_first_marker();
        test_round_robin();
        test_idle_fill();
        test_back_to_back();
        test_frame_wrap();
        test_reset_in_issue();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
